uart_cmd_parser: RTL and testbench

//  Line-oriented command parser between the UART byte receiver and the PWM/response stages of top_pwm_uart.

---
 rtl/uart_cmd_parser.sv | 269 ++++++++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - line-buffered UART command decoder driving PWM duty/scale registers
`timescale 1ns/1ps
module uart_cmd_parser #(
  parameter int BUF_DEPTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic [6:0] duty_percent_o,
  output logic [1:0] pow2_o,
  output logic [1:0] pow5_o,
  output logic [1:0] resp_code_o,
  output logic       resp_valid_o,
  input  logic       resp_ready_i,
  output logic       busy_o,
  output logic       drop_o
);

  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int LW = $clog2(BUF_DEPTH + 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(BUF_DEPTH);

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

  localparam logic [1:0] RC_OK     = 2'd0;
  localparam logic [1:0] RC_FAIL   = 2'd1;
  localparam logic [1:0] RC_HELP   = 2'd2;
  localparam logic [1:0] RC_STATUS = 2'd3;

  typedef enum logic [1:0] {
    COLLECT,
    PARSE,
    EVAL,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [7:0]    line_buf [BUF_DEPTH];
  logic [LW-1:0] len;
  logic          ovf;

  // Parser walk position and per-keyword "still matching" flags
  logic [LW-1:0] idx;
  logic [7:0]    cur;
  logic [2:0]    pos;
  logic          m_dc;
  logic          m_p2;
  logic          m_p5;
  logic          m_help;
  logic          m_stat;
  logic [6:0]    acc;
  logic [1:0]    pdig;
  logic [1:0]    code_q;

  logic          is_dig;
  logic          is_pdig;
  logic          hit_dc;
  logic          hit_p2;
  logic          hit_p5;
  logic          hit_help;
  logic          hit_stat;

  logic          rx_store;

  assign cur         = line_buf[idx[AW-1:0]];
  assign resp_code_o = code_q;
  assign rx_store    = rx_valid_i && (state == COLLECT) &&
                       (rx_data_i != CH_LF) && (rx_data_i != CH_CR);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and status outputs
  always_comb begin
    state_nxt    = state;
    busy_o       = 1'b0;
    resp_valid_o = 1'b0;
    case (state)
      COLLECT: begin
        if (rx_valid_i && (rx_data_i == CH_LF) && ((len != '0) || ovf)) begin
          state_nxt = PARSE;
        end
      end
      PARSE: begin
        busy_o = 1'b1;
        if (idx == len) begin
          state_nxt = EVAL;
        end
      end
      EVAL: begin
        busy_o    = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        busy_o       = 1'b1;
        resp_valid_o = 1'b1;
        if (resp_ready_i) begin
          state_nxt = COLLECT;
        end
      end
      default: begin
        state_nxt = COLLECT;
      end
    endcase
  end

  // Line buffer storage; contents beyond len are never read so no reset needed
  always_ff @(posedge clk) begin
    if (rx_store && (len < DEPTH_L)) begin
      line_buf[len[AW-1:0]] <= rx_data_i;
    end
  end

  // Fill level, overflow flag and drop strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      len    <= '0;
      ovf    <= 1'b0;
      drop_o <= 1'b0;
    end else begin
      drop_o <= 1'b0;
      if (rx_valid_i && (state != COLLECT)) begin
        drop_o <= 1'b1;
      end else if (rx_store) begin
        if (len < DEPTH_L) begin
          len <= len + 1'b1;
        end else begin
          ovf    <= 1'b1;
          drop_o <= 1'b1;
        end
      end
      if ((state == RESP) && resp_ready_i) begin
        len <= '0;
        ovf <= 1'b0;
      end
    end
  end

  // Per-position keyword character match for the byte under the parse pointer
  always_comb begin
    pos      = (idx > LW'(7)) ? 3'd7 : idx[2:0];
    is_dig   = (cur >= "0") && (cur <= "9");
    is_pdig  = (cur >= "0") && (cur <= "3");
    hit_dc   = 1'b0;
    hit_p2   = 1'b0;
    hit_p5   = 1'b0;
    hit_help = 1'b0;
    hit_stat = 1'b0;
    case (pos)
      3'd0: begin
        hit_dc   = (cur == "D");
        hit_p2   = (cur == "P");
        hit_p5   = (cur == "P");
        hit_help = (cur == "H");
        hit_stat = (cur == "S");
      end
      3'd1: begin
        hit_dc   = (cur == "C");
        hit_p2   = (cur == "O");
        hit_p5   = (cur == "O");
        hit_help = (cur == "E");
        hit_stat = (cur == "T");
      end
      3'd2: begin
        hit_dc   = is_dig;
        hit_p2   = (cur == "W");
        hit_p5   = (cur == "W");
        hit_help = (cur == "L");
        hit_stat = (cur == "A");
      end
      3'd3: begin
        hit_dc   = is_dig;
        hit_p2   = (cur == "2");
        hit_p5   = (cur == "5");
        hit_help = (cur == "P");
        hit_stat = (cur == "T");
      end
      3'd4: begin
        hit_p2   = is_pdig;
        hit_p5   = is_pdig;
        hit_stat = (cur == "U");
      end
      3'd5: begin
        hit_stat = (cur == "S");
      end
      default: begin
        hit_dc = 1'b0;
      end
    endcase
  end

  // Parse walk: one stored byte per cycle, then one idle cycle at idx == len
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      m_dc   <= 1'b0;
      m_p2   <= 1'b0;
      m_p5   <= 1'b0;
      m_help <= 1'b0;
      m_stat <= 1'b0;
      acc    <= '0;
      pdig   <= '0;
    end else if (state == COLLECT) begin
      idx    <= '0;
      m_dc   <= 1'b1;
      m_p2   <= 1'b1;
      m_p5   <= 1'b1;
      m_help <= 1'b1;
      m_stat <= 1'b1;
      acc    <= '0;
      pdig   <= '0;
    end else if ((state == PARSE) && (idx != len)) begin
      idx    <= idx + 1'b1;
      m_dc   <= m_dc & hit_dc;
      m_p2   <= m_p2 & hit_p2;
      m_p5   <= m_p5 & hit_p5;
      m_help <= m_help & hit_help;
      m_stat <= m_stat & hit_stat;
      if (pos == 3'd2) begin
        acc <= {3'd0, cur[3:0]};
      end else if (pos == 3'd3) begin
        acc <= acc * 7'd10 + {3'd0, cur[3:0]};
      end
      if (pos == 3'd4) begin
        pdig <= cur[1:0];
      end
    end
  end

  // Decision and register commit; exact lengths reject truncated or extended keywords
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_percent_o <= '0;
      pow2_o         <= '0;
      pow5_o         <= '0;
      code_q         <= RC_OK;
    end else if (state == EVAL) begin
      if (ovf) begin
        code_q <= RC_FAIL;
      end else if (m_dc && ((len == LW'(3)) || (len == LW'(4)))) begin
        duty_percent_o <= acc;
        code_q         <= RC_OK;
      end else if (m_p2 && (len == LW'(5))) begin
        pow2_o <= pdig;
        code_q <= RC_OK;
      end else if (m_p5 && (len == LW'(5))) begin
        pow5_o <= pdig;
        code_q <= RC_OK;
      end else if (m_help && (len == LW'(4))) begin
        code_q <= RC_HELP;
      end else if (m_stat && (len == LW'(6))) begin
        code_q <= RC_STATUS;
      end else begin
        code_q <= RC_FAIL;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - scoreboard bench for uart_cmd_parser
`timescale 1ns/1ps
module tb_uart_cmd_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [6:0] duty_percent;
  logic [1:0] pow2;
  logic [1:0] pow5;
  logic [1:0] resp_code;
  logic       resp_valid;
  logic       resp_ready;
  logic       busy;
  logic       drop;

  always #10 clk = ~clk;

  uart_cmd_parser #(.BUF_DEPTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data_i      (rx_data),
    .rx_valid_i     (rx_valid),
    .duty_percent_o (duty_percent),
    .pow2_o         (pow2),
    .pow5_o         (pow5),
    .resp_code_o    (resp_code),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .busy_o         (busy),
    .drop_o         (drop)
  );

  typedef struct {
    int code;
    int duty;
    int p2;
    int p5;
    int rise;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         drops = 0;
  int         resp_cnt = 0;
  logic       prev_valid = 1'b0;
  logic [1:0] prev_code = 2'd0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops one expectation per rising response, checks hold stability while stalled
  always @(negedge clk) begin
    if (drop) drops++;
    if (resp_valid && !prev_valid) begin
      resp_cnt++;
      chk("resp_expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("resp_code", resp_code, mon_e.code);
        chk("resp_rise_cycle", cyc, mon_e.rise);
        chk("duty", duty_percent, mon_e.duty);
        chk("pow2", pow2, mon_e.p2);
        chk("pow5", pow5, mon_e.p5);
      end
    end else if (resp_valid && prev_valid) begin
      chk("code_stable", resp_code, prev_code);
    end
    prev_valid = resp_valid;
    prev_code  = resp_code;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_raw(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !resp_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("idle_timeout", int'(ok), 1);
  endtask

  // Sends body + LF and queues the hand-computed response; rise = LF edge + stored len + 2
  task automatic send_line(input string body, input int code, input int duty,
                           input int p2, input int p5, input bit wait_done);
    exp_t e;
    int n;
    n = 0;
    for (int i = 0; i < body.len(); i++) begin
      if (body[i] != 8'h0D) n++;
    end
    if (n > 32) n = 32;
    send_raw(body);
    send_byte(8'h0A);
    e.code = code;
    e.duty = duty;
    e.p2   = p2;
    e.p5   = p5;
    e.rise = cyc + n + 2;
    sb.push_back(e);
    if (wait_done) wait_idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    string s40;
    int d0;
    int r0;
    bit ok;

    rst        = 1'b1;
    rx_data    = 8'h00;
    rx_valid   = 1'b0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("reset_duty", duty_percent, 0);
    chk("reset_pow2", pow2, 0);
    chk("reset_pow5", pow5, 0);
    chk("reset_code", resp_code, 0);
    chk("reset_valid", resp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_drop", drop, 0);

    // Basic duty command
    send_line("DC50", 0, 50, 0, 0, 1'b1);

    // Period scale exponents
    send_line("POW23", 0, 50, 3, 0, 1'b1);
    send_line("POW52", 0, 50, 3, 2, 1'b1);

    // Boundaries: max duty, three digits, out-of-range exponent, malformed forms
    send_line("DC99", 0, 99, 3, 2, 1'b1);
    send_line("DC100", 1, 99, 3, 2, 1'b1);
    send_line("POW24", 1, 99, 3, 2, 1'b1);
    send_line("DC", 1, 99, 3, 2, 1'b1);
    send_line("DC5x", 1, 99, 3, 2, 1'b1);
    send_line("DC7", 0, 7, 3, 2, 1'b1);
    send_line("DC\r99", 0, 99, 3, 2, 1'b1);

    // Overflow: 32 stored, 8 dropped, then a clean HELP
    s40 = "";
    for (int i = 0; i < 40; i++) s40 = {s40, "A"};
    d0 = drops;
    send_line(s40, 1, 99, 3, 2, 1'b1);
    chk("ovf_drop_count", drops - d0, 8);
    send_line("HELP", 2, 99, 3, 2, 1'b1);

    // Stalled response with bytes arriving while busy
    resp_ready = 1'b0;
    send_line("DC10", 0, 10, 3, 2, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (resp_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("stall_valid_timeout", int'(ok), 1);
    d0 = drops;
    send_raw("DC77");
    send_byte(8'h0A);
    repeat (90) @(negedge clk);
    chk("stall_valid_held", resp_valid, 1);
    chk("stall_code_held", resp_code, 0);
    chk("busy_drop_count", drops - d0, 5);
    resp_ready = 1'b1;
    wait_idle();
    chk("duty_after_busy_bytes", duty_percent, 10);

    // Bare CR LF produces nothing and drops nothing
    r0 = resp_cnt;
    d0 = drops;
    send_byte(8'h0D);
    send_byte(8'h0A);
    repeat (20) @(negedge clk);
    chk("crlf_no_resp", resp_cnt, r0);
    chk("crlf_no_drop", drops - d0, 0);
    send_line("POW21", 0, 10, 1, 2, 1'b1);

    // Reset during PARSE discards the line
    r0 = resp_cnt;
    send_raw("STATUS");
    send_byte(8'h0A);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_duty", duty_percent, 0);
    chk("midrst_pow2", pow2, 0);
    chk("midrst_pow5", pow5, 0);
    chk("midrst_code", resp_code, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", resp_valid, 0);
    repeat (20) @(negedge clk);
    chk("midrst_no_resp", resp_cnt, r0);
    send_line("STATUS", 3, 0, 0, 0, 1'b1);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
